fetch_sequencer: RTL and testbench

//  Program-counter and fetch controller for the 64-entry instruction ROM (Instruction_Mem).
//  - Drives PCAdress and samples the ROM's combinational Instruction_out in the same cycle.
//  - Holds the fetched word in an instruction register and hands it to decode over valid/ready.
//  - Handles start, branch redirect/flush and HALT.

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// PC and fetch controller for a combinational instruction ROM; fetched words go to decode over
// valid/ready. Define FETCH_CNT_EN to add the saturating fetch_count output.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 6,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = 4'hF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  PCAdress,
   input  logic [INSTR_W-1:0] Instruction_in,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [INSTR_W-1:0] ir_out,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic               halted
`ifdef FETCH_CNT_EN
   ,
   output logic [15:0]        fetch_count
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
   logic                valid_q, valid_d;
   logic                slot_free;

   assign slot_free = !valid_q || ir_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ir_pc_d = ir_pc_q;
      valid_d = valid_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               pc_d    = RESET_PC;
               valid_d = 1'b0;
            end
         end
         StRun: begin
            // A redirect flushes the slot and suppresses this cycle's capture, even a HALT.
            if (branch_valid) begin
               pc_d    = branch_target;
               valid_d = 1'b0;
            end else if (slot_free) begin
               ir_d    = Instruction_in;
               ir_pc_d = pc_q;
               valid_d = 1'b1;
               if (Instruction_in[INSTR_W-1 -: 4] == HALT_OP) begin
                  state_d = StHalt;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         StHalt: begin
            if (start) begin
               state_d = StRun;
               pc_d    = RESET_PC;
               valid_d = 1'b0;
            end else if (ir_ready) begin
               valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         ir_pc_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ir_pc_q <= ir_pc_d;
         valid_q <= valid_d;
      end
   end

   assign PCAdress = pc_q;
   assign ir_out   = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = valid_q;
   assign halted   = (state_q == StHalt);

`ifdef FETCH_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        capture, restart;

   assign capture = (state_q == StRun) && !branch_valid && slot_free;
   assign restart = start && (state_q != StRun);

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (capture && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: run, stall, branch, HALT, wrap, async reset and
// (with FETCH_CNT_EN) the fetch counter.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  PCAdress;
   logic [31:0] Instruction_in;
   logic        branch_valid;
   logic [5:0]  branch_target;
   logic [31:0] ir_out;
   logic [5:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        halted;
`ifdef FETCH_CNT_EN
   logic [15:0] fetch_count;
`endif

   logic [31:0] rom [64];
   int          n_cmp;
   int          n_err;

   fetch_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .PCAdress       (PCAdress),
      .Instruction_in (Instruction_in),
      .branch_valid   (branch_valid),
      .branch_target  (branch_target),
      .ir_out         (ir_out),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .halted         (halted)
`ifdef FETCH_CNT_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   assign Instruction_in = rom[PCAdress];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Checks the instruction register after a capture from address a.
   task automatic check_cap(input string tag, input logic [5:0] a, input logic [5:0] next_pc);
      check({tag, ".ir_pc"}, 32'(ir_pc), 32'(a));
      check({tag, ".ir_out"}, ir_out, rom[a]);
      check({tag, ".ir_valid"}, 32'(ir_valid), 32'd1);
      check({tag, ".pc"}, 32'(PCAdress), 32'(next_pc));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 64; i++) rom[i] = {4'h1, 22'd0, 6'(i)};
      rom[2]  = 32'h2000_0002;
      rom[5]  = 32'hF000_0000;
      rom[40] = 32'h4000_0028;
      rom[62] = 32'h5000_003E;
      rom[63] = 32'h5000_003F;
      rst_n         = 1'b0;
      start         = 1'b0;
      branch_valid  = 1'b0;
      branch_target = '0;
      ir_ready      = 1'b1;

      #3;
      check("rst.pc", 32'(PCAdress), 32'd0);
      check("rst.ir_out", ir_out, 32'd0);
      check("rst.ir_pc", 32'(ir_pc), 32'd0);
      check("rst.ir_valid", 32'(ir_valid), 32'd0);
      check("rst.halted", 32'(halted), 32'd0);
      #9 rst_n = 1'b1;

      // Idle: no fetch until start.
      tick;
      check("idle.ir_valid", 32'(ir_valid), 32'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("run.pc0", 32'(PCAdress), 32'd0);
      check("run.valid0", 32'(ir_valid), 32'd0);
      tick; check_cap("t1.c0", 6'd0, 6'd1);
      tick; check_cap("t1.c1", 6'd1, 6'd2);
      tick; check_cap("t1.c2", 6'd2, 6'd3);

      // Stall: everything frozen while ir_valid && !ir_ready.
      ir_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check_cap("t2.stall", 6'd2, 6'd3);
      end
      ir_ready = 1'b1;
      tick; check_cap("t2.rel", 6'd3, 6'd4);

      // Branch redirect flushes the slot.
      branch_valid  = 1'b1;
      branch_target = 6'd40;
      tick;
      branch_valid = 1'b0;
      check("t3.flush", 32'(ir_valid), 32'd0);
      check("t3.pc", 32'(PCAdress), 32'd40);
      tick; check_cap("t3.c40", 6'd40, 6'd41);

      // Branch to the HALT word, capture it.
      branch_valid  = 1'b1;
      branch_target = 6'd5;
      tick;
      branch_valid = 1'b0;
      check("t4.pc5", 32'(PCAdress), 32'd5);
      tick;
      check_cap("t4.halt", 6'd5, 6'd5);
      check("t4.halted", 32'(halted), 32'd1);
      // Branch ignored in HALT; unconsumed HALT word held.
      ir_ready      = 1'b0;
      branch_valid  = 1'b1;
      branch_target = 6'd20;
      tick;
      branch_valid = 1'b0;
      check_cap("t4.hold", 6'd5, 6'd5);
      check("t4.halted2", 32'(halted), 32'd1);
      ir_ready = 1'b1;
      tick;
      check("t4.consumed", 32'(ir_valid), 32'd0);
      check("t4.halted3", 32'(halted), 32'd1);
      check("t4.pc_hold", 32'(PCAdress), 32'd5);
      // start beats branch in HALT.
      start         = 1'b1;
      branch_valid  = 1'b1;
      branch_target = 6'd30;
      tick;
      start        = 1'b0;
      branch_valid = 1'b0;
      check("t4.restart.pc", 32'(PCAdress), 32'd0);
      check("t4.restart.valid", 32'(ir_valid), 32'd0);
      check("t4.restart.halted", 32'(halted), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick;
         check_cap("t4.rerun", 6'(i), 6'(i + 1));
      end
      // Branch coinciding with a HALT capture: branch wins.
      branch_valid  = 1'b1;
      branch_target = 6'd62;
      tick;
      branch_valid = 1'b0;
      check("t4.bwin.halted", 32'(halted), 32'd0);
      check("t4.bwin.pc", 32'(PCAdress), 32'd62);
      check("t4.bwin.valid", 32'(ir_valid), 32'd0);

      // Wrap 62, 63, 0, 1.
      tick; check_cap("t5.c62", 6'd62, 6'd63);
      tick; check_cap("t5.c63", 6'd63, 6'd0);
      tick; check_cap("t5.c0", 6'd0, 6'd1);
      tick; check_cap("t5.c1", 6'd1, 6'd2);

      // Asynchronous reset mid-cycle.
      #2 rst_n = 1'b0;
      #1;
      check("t5.arst.pc", 32'(PCAdress), 32'd0);
      check("t5.arst.ir_out", ir_out, 32'd0);
      check("t5.arst.ir_pc", 32'(ir_pc), 32'd0);
      check("t5.arst.valid", 32'(ir_valid), 32'd0);
      check("t5.arst.halted", 32'(halted), 32'd0);
      #4 rst_n = 1'b1;

`ifdef FETCH_CNT_EN
      rom[5] = 32'h1000_0005;
      rom[9] = 32'hF000_0009;
      tick;
      check("t6.cnt_rst", 32'(fetch_count), 32'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick;
      check("t6.cnt10", 32'(fetch_count), 32'd10);
      check("t6.halted", 32'(halted), 32'd1);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("t6.cnt_clr", 32'(fetch_count), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
